// File: rtl/emcu_ahb_initiator.sv
// Single-beat AHB-Lite initiator for the EMCU INITEXP0 port: one request in, one NONSEQ SINGLE out.
// Optional data-phase wait-state timeout is enabled by defining EMCU_AHB_INIT_TIMEOUT_EN.
module emcu_ahb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        hsel_q, hsel_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        req_illegal;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_byte_shift;
    logic [31:0] rd_half_shift;
    logic [31:0] rd_steered;

    assign req_illegal = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_addr[0]) ||
                         (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_comb begin
        case (size_q)
            2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
            2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    // The slave places each lane at its natural byte position; shift it down to bit 0.
    assign rd_byte_shift = hrdata >> {haddr_q[1:0], 3'b000};
    assign rd_half_shift = hrdata >> {haddr_q[1], 4'b0000};

    always_comb begin
        case (size_q)
            2'b00:   rd_steered = {24'd0, rd_byte_shift[7:0]};
            2'b01:   rd_steered = {16'd0, rd_half_shift[15:0]};
            default: rd_steered = hrdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hsel_d      = hsel_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        hwdata_d    = hwdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        size_d   = req_size;
                        wdata_d  = req_wdata;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    state_d  = ST_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_lanes;
                    err_d    = 1'b0;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
                    cnt_d    = 16'd0;
`endif
                end
            end
            ST_DATA: begin
                if (hresp) begin
                    err_d = 1'b1;
                end
                if (hready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q | hresp;
                    rsp_rdata_d = (err_q || hresp || hwrite_q) ? 32'd0 : rd_steered;
                end
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= 32'd0;
            hwrite_q    <= 1'b0;
            size_q      <= 2'b00;
            wdata_q     <= 32'd0;
            hwdata_q    <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
            cnt_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            hwdata_q    <= hwdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign hsel      = hsel_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = {1'b0, size_q};
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_emcu_ahb_initiator.sv
// Directed bench for emcu_ahb_initiator: transfers, lane steering, illegal requests, waits, errors, reset, timeout.
module tb_emcu_ahb_initiator;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int tests = 0;
    int fails = 0;
    int seen;

    emcu_ahb_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents a request for one accepting edge, then withdraws it.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_size = 2'b00; req_wdata = 32'd0; hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp", {rsp_valid, rsp_err, 30'd0}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_bus_ctl", {26'd0, hsel, htrans, hwrite, hsize}, 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("const_hburst_hprot", {25'd0, hburst, hprot}, 32'h0000_0003);

        // Zero-wait word read
        hrdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h2000_0010, 2'b10, 32'd0);
        check("wr_addr_phase", {hsel, htrans, hwrite, hsize, req_ready}, {1'b1, 2'b10, 1'b0, 3'b010, 1'b0});
        check("wr_haddr", haddr, 32'h2000_0010);
        tick();
        check("wr_data_phase", {hsel, htrans, rsp_valid}, 4'b0000);
        tick();
        check("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("wr_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();
        check("wr_done", {rsp_valid, req_ready}, 2'b01);

        // Byte write, then byte read of the same top lane
        issue(1'b1, 32'h4001_0003, 2'b00, 32'h0000_00A5);
        check("bw_addr_phase", {htrans, hwrite, hsize}, {2'b10, 1'b1, 3'b000});
        tick();
        check("bw_hwdata", hwdata, 32'hA5A5_A5A5);
        tick();
        check("bw_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("bw_rdata", rsp_rdata, 32'd0);
        tick();
        hrdata = 32'h1234_5678;
        issue(1'b0, 32'h4001_0003, 2'b00, 32'd0);
        tick(); tick();
        check("br_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("br_rdata", rsp_rdata, 32'h0000_0012);
        tick();

        // Halfword read of the upper half, halfword write lanes
        hrdata = 32'hCAFE_BABE;
        issue(1'b0, 32'h2000_0002, 2'b01, 32'd0);
        tick(); tick();
        check("hr_rdata", rsp_rdata, 32'h0000_CAFE);
        tick();
        issue(1'b1, 32'h2000_0004, 2'b01, 32'h0000_1234);
        tick();
        check("hw_hwdata", hwdata, 32'h1234_1234);
        tick(); tick();

        // Misaligned halfword and illegal size: immediate error, no bus traffic
        issue(1'b0, 32'h2000_0001, 2'b01, 32'd0);
        check("ill_half_rsp", {rsp_valid, rsp_err, hsel, htrans}, 5'b11000);
        check("ill_half_rdata", rsp_rdata, 32'd0);
        tick();
        check("ill_half_done", {rsp_valid, req_ready, htrans}, 4'b0100);
        issue(1'b1, 32'h2000_0000, 2'b11, 32'd0);
        check("ill_size_rsp", {rsp_valid, rsp_err, hsel, htrans}, 5'b11000);
        tick();
        issue(1'b0, 32'h2000_0002, 2'b10, 32'd0);
        check("ill_word_rsp", {rsp_valid, rsp_err, hsel, htrans}, 5'b11000);
        tick();

        // Three data-phase waits, then a two-cycle error response
        hrdata = 32'hFFFF_FFFF;
        issue(1'b0, 32'h2000_0020, 2'b10, 32'h1122_3344);
        tick();
        hready = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (haddr !== 32'h2000_0020 || hwdata !== 32'h1122_3344 || rsp_valid !== 1'b0) seen++;
            tick();
        end
        hresp = 1'b1;
        if (haddr !== 32'h2000_0020 || hwdata !== 32'h1122_3344 || rsp_valid !== 1'b0) seen++;
        tick();
        hready = 1'b1;
        if (haddr !== 32'h2000_0020 || hwdata !== 32'h1122_3344 || rsp_valid !== 1'b0) seen++;
        check("wait_stable", 32'(seen), 32'd0);
        tick();
        hresp = 1'b0;
        check("err_rsp", {rsp_valid, rsp_err}, 2'b11);
        check("err_rdata", rsp_rdata, 32'd0);
        tick();
        // Sticky flag must not leak into the next transfer
        hrdata = 32'h0BAD_F00D;
        issue(1'b0, 32'h2000_0024, 2'b10, 32'd0);
        tick(); tick();
        check("post_err_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("post_err_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();

        // Reset during the data phase abandons the transfer
        issue(1'b0, 32'h2000_0030, 2'b10, 32'd0);
        tick();
        hready = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        hready = 1'b1;
        check("rst_mid", {htrans, hsel, req_ready, rsp_valid}, 5'b00010);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);

        // Slave stuck with hready low in the data phase
        issue(1'b0, 32'h2000_0040, 2'b10, 32'd0);
        tick();
        hready = 1'b0;
        seen = 0;
`ifdef EMCU_AHB_INIT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        check("tmo_early", 32'(seen), 32'd0);
        tick();
        check("tmo_rsp", {rsp_valid, rsp_err}, 2'b11);
        check("tmo_rdata", rsp_rdata, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        check("no_tmo", 32'(seen), 32'd0);
        check("no_tmo_busy", 32'(req_ready), 32'd0);
`endif
        hready = 1'b1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/emcu_ahb_initiator.md
# emcu_ahb_initiator

Fabric-side AHB-Lite initiator driving the EMCU INITEXP0 port, giving fabric logic single-beat read/write access to the Cortex-M3 bus matrix (SRAM, peripherals, GPIO). It accepts one request at a time on a valid/ready interface and runs one NONSEQ SINGLE transfer per request. It also performs byte-lane steering and misalignment checks, and returns read data or an error on a one-cycle response strobe.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum consecutive wait-state cycles in the data phase before the transfer is abandoned; only used with the timeout macro; range 1..65535.

Ports:
- clk  in  1  system clock, same as EMCU FCLK
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_wdata  in  32  right-justified write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  32  right-justified, zero-extended read data; 0 for writes and errors
- rsp_err  out  1  qualified by rsp_valid
- hsel  out  1  to INITEXP0HSEL
- haddr  out  32  to INITEXP0HADDR
- htrans  out  2  to INITEXP0HTRANS; only 00 IDLE or 10 NONSEQ
- hwrite  out  1  to INITEXP0HWRITE
- hsize  out  3  to INITEXP0HSIZE; {0, req_size}
- hburst  out  3  constant 000 (SINGLE)
- hprot  out  4  constant 0011 (data, privileged)
- hwdata  out  32  to INITEXP0HWDATA
- hrdata  in  32  from INITEXP0HRDATA
- hready  in  1  from INITEXP0HREADY
- hresp  in  1  from INITEXP0HRESP

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - On acceptance, latch the request.
  - If the request is illegal, go to RESP with error. Illegal means: req_size=11; halfword with addr[0]=1; word with addr[1:0]≠00.
  - Otherwise go to ADDR.
- **ADDR:**
  - Drive hsel=1, htrans=NONSEQ, and haddr/hwrite/hsize from the latched request.
  - Hold all of them stable while hready=0.
  - On hready=1, go to DATA.
- **DATA:**
  - Drive htrans=IDLE and hsel=0.
  - Drive hwdata for the whole phase:
    - byte: {4{wdata[7:0]}}
    - halfword: {2{wdata[15:0]}}
    - word: wdata
  - Any cycle with hresp=1 sets a sticky error flag.
  - On hready=1, capture read data and go to RESP. Read data is selected by addr[1:0]:
    - byte: hrdata[8*a+7:8*a]
    - halfword: hrdata[16*a1+15:16*a1]
  - When an error is captured, rsp_rdata=0.
- **RESP:** rsp_valid=1 for exactly one cycle, rsp_err=sticky flag, then go to IDLE and clear the flag.
- Only one transfer is ever outstanding; no pipelining of address and data phases.
- Reset mid-operation: the transfer is abandoned, no response is issued, and the state returns to IDLE.

## Timing
- Reset values:
  - state IDLE, req_ready=1
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
  - hsel=0, htrans=00, haddr=0, hwrite=0, hsize=000, hwdata=0
- All bus outputs and rsp_* are registered.
- Zero-wait latency: accept at edge T, ADDR in cycle T+1, DATA in T+2, rsp_valid in T+3.
  - Each cycle of hready=0 in ADDR or DATA adds one cycle.
- Illegal request: accept at T, rsp_valid with rsp_err=1 in T+1, and no bus activity.
- Back-to-back: the next request can be accepted the cycle after RESP, so the minimum period is 4 cycles.
- Two-cycle AHB error response: the flag is set on the first cycle (hresp=1, hready=0); completion happens on the second cycle.

## Configuration
- EMCU_AHB_INIT_TIMEOUT_EN defined:
  - A 16-bit counter counts consecutive DATA cycles with hready=0.
  - On reaching TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_rdata=0.
  - The counter clears on entry to DATA.
- Not defined: no counter; DATA waits indefinitely and TIMEOUT_CYCLES is ignored.

## Test plan
- Word read 0x2000_0010, hready=1, hrdata=0xDEADBEEF -> htrans=10 for one cycle; rsp_valid 3 cycles after accept; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Byte write 0xA5 to 0x4001_0003 -> hsize=000; hwdata=0xA5A5A5A5 in the data phase; then byte read from the same address with hrdata=0x12345678 -> rsp_rdata=0x00000012.
- Halfword request at 0x2000_0001 -> no NONSEQ issued; rsp_valid at T+1 with rsp_err=1.
- Slave holds hready=0 for 3 cycles in DATA, then a two-cycle hresp=1 -> haddr and hwdata stable throughout; rsp_err=1; rsp_rdata=0.
- rst_i asserted during DATA -> next cycle htrans=00, hsel=0, req_ready=1; no rsp_valid is ever issued for that request.
- With the macro and TIMEOUT_CYCLES=8, hready stuck at 0 -> rsp_valid with rsp_err=1 after 8 wait cycles; without the macro -> no rsp_valid after 100 cycles.
